// File: rtl/crank_wheel_pkg.sv
// Shared definitions for the crank-wheel tooth generator.
//   CWG_MIN_PER     : shortest allowed slot length in ticks (smaller requests are clamped)
//   CWG_DEF_TEETH   : default slot count per revolution, including missing slots
//   CWG_DEF_MISSING : default count of missing slots at the end of a revolution
//   cwg_state_e     : generator FSM state encoding
package crank_wheel_pkg;

  localparam int unsigned CWG_MIN_PER     = 2;
  localparam int unsigned CWG_DEF_TEETH   = 60;
  localparam int unsigned CWG_DEF_MISSING = 2;

  typedef enum logic [1:0] {
    CWG_IDLE = 2'd0,
    CWG_HIGH = 2'd1,
    CWG_LOW  = 2'd2,
    CWG_GAP  = 2'd3
  } cwg_state_e;

endpackage

// File: rtl/crank_wheel_tick.sv
// Machine-cycle rising-edge detector.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   mc_i   : machine-cycle strobe
//   tick_o : registered one-clock pulse per rising edge of mc_i
module crank_wheel_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mc_i,
  output logic tick_o
);

  logic mc_q;
  logic tick_q;

  // Previous strobe level and registered edge pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mc_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      mc_q   <= mc_i;
      tick_q <= mc_i & ~mc_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/crank_wheel_gen.sv
// N-minus-M missing-tooth crank-wheel pulse generator (pht transmitter).
//   crank_wheel_gen_clock_i         : system clock
//   crank_wheel_gen_reset_i         : asynchronous active-high reset
//   crank_wheel_gen_machine_cycle_i : machine-cycle strobe, one tick per rising edge
//   crank_wheel_gen_enable_i        : run control level
//   crank_wheel_gen_period_i        : ticks per tooth slot, sampled at each slot start
//   crank_wheel_gen_pht_o           : generated tooth signal
//   crank_wheel_gen_sync_o          : one-clock pulse at the start of tooth 0
//   crank_wheel_gen_tooth_o         : current slot index
//   crank_wheel_gen_rev_o           : revolution counter
module crank_wheel_gen
  import crank_wheel_pkg::*;
#(
  parameter int unsigned TEETH   = CWG_DEF_TEETH,
  parameter int unsigned MISSING = CWG_DEF_MISSING,
  parameter int unsigned PER_W   = 16
) (
  input  logic             crank_wheel_gen_clock_i,
  input  logic             crank_wheel_gen_reset_i,
  input  logic             crank_wheel_gen_machine_cycle_i,
  input  logic             crank_wheel_gen_enable_i,
  input  logic [PER_W-1:0] crank_wheel_gen_period_i,
  output logic             crank_wheel_gen_pht_o,
  output logic             crank_wheel_gen_sync_o,
  output logic [7:0]       crank_wheel_gen_tooth_o,
  output logic [7:0]       crank_wheel_gen_rev_o
);

  localparam logic [7:0]       LAST_TOOTH = 8'(TEETH - 1);
  localparam logic [7:0]       FIRST_GAP  = 8'(TEETH - MISSING);
  localparam logic [PER_W-1:0] MIN_PER    = PER_W'(CWG_MIN_PER);

  cwg_state_e       state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [7:0]       tooth_q, tooth_d;
  logic [7:0]       rev_q, rev_d;
  logic             pht_q, pht_d;
  logic             sync_q, sync_d;

  logic             tick;
  logic [PER_W-1:0] per_in_c;
  logic [PER_W-1:0] half_c;
  logic [PER_W-1:0] cnt_inc_c;
  logic [7:0]       next_tooth_c;

  crank_wheel_tick u_tick (
    .clk_i  (crank_wheel_gen_clock_i),
    .rst_i  (crank_wheel_gen_reset_i),
    .mc_i   (crank_wheel_gen_machine_cycle_i),
    .tick_o (tick)
  );

  assign per_in_c     = (crank_wheel_gen_period_i < MIN_PER) ? MIN_PER : crank_wheel_gen_period_i;
  assign half_c       = per_q >> 1;
  assign cnt_inc_c    = cnt_q + PER_W'(1);
  assign next_tooth_c = tooth_q + 8'd1;

  // cnt_q holds the number of ticks already spent in the current slot,
  // counting the tick that opened it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    tooth_d = tooth_q;
    rev_d   = rev_q;
    pht_d   = pht_q;
    sync_d  = 1'b0;

    if (!crank_wheel_gen_enable_i) begin
      // Disable wins over a coincident tick.
      state_d = CWG_IDLE;
      cnt_d   = '0;
      tooth_d = 8'd0;
      pht_d   = 1'b0;
    end else if (tick) begin
      case (state_q)
        CWG_IDLE: begin
          state_d = CWG_HIGH;
          cnt_d   = PER_W'(1);
          per_d   = per_in_c;
          tooth_d = 8'd0;
          rev_d   = rev_q + 8'd1;
          pht_d   = 1'b1;
          sync_d  = 1'b1;
        end
        CWG_HIGH: begin
          cnt_d = cnt_inc_c;
          if (cnt_q == half_c) begin
            state_d = CWG_LOW;
            pht_d   = 1'b0;
          end
        end
        CWG_LOW: begin
          if (cnt_q == per_q) begin
            cnt_d   = PER_W'(1);
            per_d   = per_in_c;
            tooth_d = next_tooth_c;
            if (next_tooth_c >= FIRST_GAP) begin
              state_d = CWG_GAP;
            end else begin
              state_d = CWG_HIGH;
              pht_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        CWG_GAP: begin
          if (cnt_q == per_q) begin
            cnt_d = PER_W'(1);
            per_d = per_in_c;
            if (tooth_q == LAST_TOOTH) begin
              state_d = CWG_HIGH;
              tooth_d = 8'd0;
              rev_d   = rev_q + 8'd1;
              pht_d   = 1'b1;
              sync_d  = 1'b1;
            end else begin
              tooth_d = next_tooth_c;
            end
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
        default: state_d = CWG_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge crank_wheel_gen_clock_i or posedge crank_wheel_gen_reset_i) begin
    if (crank_wheel_gen_reset_i) begin
      state_q <= CWG_IDLE;
      cnt_q   <= '0;
      per_q   <= MIN_PER;
      tooth_q <= 8'd0;
      rev_q   <= 8'd0;
      pht_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      tooth_q <= tooth_d;
      rev_q   <= rev_d;
      pht_q   <= pht_d;
      sync_q  <= sync_d;
    end
  end

  assign crank_wheel_gen_pht_o   = pht_q;
  assign crank_wheel_gen_sync_o  = sync_q;
  assign crank_wheel_gen_tooth_o = tooth_q;
  assign crank_wheel_gen_rev_o   = rev_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Self-checking bench for crank_wheel_gen.
module tb_crank_wheel_gen;

  localparam int TEETH   = 60;
  localparam int MISSING = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mc  = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] per = 16'd0;
  logic        pht;
  logic        sync;
  logic [7:0]  tooth;
  logic [7:0]  rev;

  always #10 clk = ~clk;

  crank_wheel_gen #(.TEETH(60), .MISSING(2), .PER_W(16)) dut (
    .crank_wheel_gen_clock_i         (clk),
    .crank_wheel_gen_reset_i         (rst),
    .crank_wheel_gen_machine_cycle_i (mc),
    .crank_wheel_gen_enable_i        (en),
    .crank_wheel_gen_period_i        (per),
    .crank_wheel_gen_pht_o           (pht),
    .crank_wheel_gen_sync_o          (sync),
    .crank_wheel_gen_tooth_o         (tooth),
    .crank_wheel_gen_rev_o           (rev)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: slot index and position within the slot, per tick.
  int m_s, m_k, m_p, m_rev;
  bit m_run, m_sync, m_mc1, m_mc2;

  function automatic int clamp(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    m_s = 0; m_k = 0; m_p = 2; m_rev = 0;
    m_run = 0; m_sync = 0; m_mc1 = 0; m_mc2 = 0;
  endtask

  // Called once per clock edge with the inputs that edge samples; a strobe
  // rise shows up at the outputs two edges after it is first sampled.
  task automatic model_edge(input bit e, input bit m, input int p);
    bit t;
    t = m_mc1 & ~m_mc2;
    m_mc2 = m_mc1;
    m_mc1 = m;
    m_sync = 0;
    if (!e) begin
      m_run = 0; m_s = 0; m_k = 0;
    end else if (t) begin
      if (!m_run) begin
        m_run = 1; m_s = 0; m_k = 0; m_p = clamp(p);
        m_rev = (m_rev + 1) % 256; m_sync = 1;
      end else begin
        m_k++;
        if (m_k == m_p) begin
          m_k = 0;
          m_p = clamp(p);
          m_s = (m_s + 1) % TEETH;
          if (m_s == 0) begin
            m_rev = (m_rev + 1) % 256; m_sync = 1;
          end
        end
      end
    end
  endtask

  // Measurement state, cleared on every reset.
  int cyc = 0;
  int n_rise, n_high, n_sync;
  bit pht_prev;
  int rise_t[$];
  int fall_t[$];
  int sync_t[$];

  task automatic clear_meas();
    n_rise = 0; n_high = 0; n_sync = 0; pht_prev = 0;
    rise_t.delete(); fall_t.delete(); sync_t.delete();
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit e, input bit m, input logic [15:0] p);
    bit ep;
    int et;
    en = e; mc = m; per = p;
    @(posedge clk);
    model_edge(e, m, int'(p));
    @(negedge clk);
    cyc++;
    ep = m_run && (m_s < TEETH - MISSING) && (m_k < m_p / 2);
    et = m_run ? m_s : 0;
    check("model", 32'({pht, sync, tooth, rev}), {14'd0, ep, m_sync, 8'(et), 8'(m_rev)});
    if (pht) n_high++;
    if (pht && !pht_prev) begin n_rise++; rise_t.push_back(cyc); end
    if (!pht && pht_prev) fall_t.push_back(cyc);
    pht_prev = pht;
    if (sync) begin
      n_sync++;
      sync_t.push_back(cyc);
      check("rev_at_sync", 32'(rev), 32'(n_sync % 256));
    end
  endtask

  task automatic run_ticks(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, p);
      step(1'b1, 1'b0, p);
    end
  endtask

  task automatic idle(input int n, input bit e, input logic [15:0] p);
    for (int i = 0; i < n; i++) step(e, 1'b0, p);
  endtask

  task automatic do_reset();
    en = 1'b0; mc = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_meas();
    check("reset_out", 32'({pht, sync, tooth, rev}), 32'd0);
  endtask

  typedef struct {
    logic [15:0] per;
    int ticks;
    int rises;
    int high_clks;
    int syncs;
    int rev;
    int tooth;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int p, h;
    bit off;
    int off_cnt;
    logic [15:0] rp;

    vecs[0] = '{16'd4, 480, 116, 464, 2, 2, 59};
    vecs[1] = '{16'd0, 240, 116, 232, 2, 2, 59};
    vecs[2] = '{16'd7, 420,  58, 348, 1, 1, 59};
    vecs[3] = '{16'd3, 101,  34,  68, 1, 1, 33};
    vecs[4] = '{16'd1,   6,   3,   6, 1, 1,  2};

    // Reset and idle with enable low.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 16'd4);
      step(1'b0, 1'b0, 16'd4);
    end
    check("idle_out", 32'({pht, sync, tooth, rev}), 32'd0);
    check("idle_sync", 32'(n_sync), 32'd0);

    // Table-driven steady runs.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      run_ticks(vecs[v].ticks, vecs[v].per);
      idle(4, 1'b1, vecs[v].per);
      check("tbl_rises", 32'(n_rise), 32'(vecs[v].rises));
      check("tbl_high",  32'(n_high), 32'(vecs[v].high_clks));
      check("tbl_syncs", 32'(n_sync), 32'(vecs[v].syncs));
      check("tbl_rev",   32'(rev),    32'(vecs[v].rev));
      check("tbl_tooth", 32'(tooth),  32'(vecs[v].tooth));
      check("tbl_pht",   32'(pht),    32'd0);
      if (vecs[v].syncs >= 2) begin
        p = clamp(int'(vecs[v].per));
        h = p / 2;
        check("tbl_rise_space", 32'(rise_t[1] - rise_t[0]), 32'(2 * p));
        check("tbl_sync_space", 32'(sync_t[1] - sync_t[0]), 32'(2 * TEETH * p));
        check("tbl_gap_low", 32'(rise_t[58] - fall_t[57]), 32'(2 * ((p - h) + MISSING * p)));
      end
    end

    // Period change mid-slot: current slot keeps 4, next slot is 6.
    do_reset();
    run_ticks(2, 16'd4);
    run_ticks(20, 16'd6);
    check("chg_high0", 32'(fall_t[0] - rise_t[0]), 32'd4);
    check("chg_slot0", 32'(rise_t[1] - rise_t[0]), 32'd8);
    check("chg_high1", 32'(fall_t[1] - rise_t[1]), 32'd6);
    check("chg_slot1", 32'(rise_t[2] - rise_t[1]), 32'd12);

    // Disable during the high phase of tooth 17, with a tick in flight.
    do_reset();
    run_ticks(70, 16'd4);
    check("dis_pre_tooth", 32'(tooth), 32'd17);
    check("dis_pre_pht", 32'(pht), 32'd1);
    step(1'b1, 1'b1, 16'd4);
    step(1'b0, 1'b0, 16'd4);
    check("dis_out", 32'({pht, tooth, rev}), {15'd0, 1'b0, 8'd0, 8'd1});
    idle(5, 1'b0, 16'd4);
    step(1'b1, 1'b1, 16'd4);
    check("reen_sync_early", 32'(sync), 32'd0);
    step(1'b1, 1'b0, 16'd4);
    check("reen_out", 32'({pht, sync, tooth, rev}), {14'd0, 1'b1, 1'b1, 8'd0, 8'd2});

    // Asynchronous reset in the gap, off the clock edge.
    do_reset();
    run_ticks(234, 16'd4);
    check("gap_tooth", 32'(tooth), 32'd58);
    check("gap_pht", 32'(pht), 32'd0);
    #3 rst = 1'b1;
    #1 check("async_rst", 32'({pht, sync, tooth, rev}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_meas();
    idle(3, 1'b1, 16'd4);
    step(1'b1, 1'b1, 16'd4);
    check("rst_sync_1clk", 32'(sync), 32'd0);
    step(1'b1, 1'b0, 16'd4);
    check("rst_sync_2clk", 32'({sync, rev}), {23'd0, 1'b1, 8'd1});

    // Revolution counter wrap at period 2 (120 ticks per revolution).
    do_reset();
    run_ticks(255 * 120, 16'd2);
    check("wrap_pre_rev", 32'(rev), 32'd255);
    check("wrap_pre_syncs", 32'(n_sync), 32'd255);
    run_ticks(1, 16'd2);
    check("wrap_rev", 32'(rev), 32'd0);
    check("wrap_syncs", 32'(n_sync), 32'd256);

    // Randomised strobe, period and enable against the model.
    do_reset();
    rp = 16'd3;
    off = 0;
    off_cnt = 0;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 49) == 0) rp = 16'($urandom_range(0, 6));
      if (off) begin
        if (off_cnt == 0) off = 0; else off_cnt--;
      end else if ($urandom_range(0, 299) == 0) begin
        off = 1;
        off_cnt = $urandom_range(1, 6);
      end
      step(!off, 1'($urandom_range(0, 1)), rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
